// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory stream reader.
package onchip_mem_pkg;

    localparam int MEM_WORDS = 15360;
    localparam int WORD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// Show-ahead FIFO with occupancy count; the head entry is visible whenever not empty.
module mem_rd_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master (latency 1, no waitrequest) feeding an Avalon-ST packet stream.
module onchip_mem_stream_reader
    import onchip_mem_pkg::state_t, onchip_mem_pkg::fifo_entry_t,
           onchip_mem_pkg::ST_IDLE, onchip_mem_pkg::ST_RUN, onchip_mem_pkg::ST_DRAIN;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int MEM_WORDS  = onchip_mem_pkg::MEM_WORDS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [1:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic              inflight_q;
    logic              first_q;
    logic              ret_sop_q, ret_eop_q;
    logic              zero_done_q;

    logic              accept, zero_req, issue, room;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              fifo_empty;
    fifo_entry_t       push_entry, head_entry;

    // Words already buffered plus the one returning this cycle must leave a slot for the next read.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign room      = occupancy < (CNT_W+1)'(FIFO_DEPTH);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        zero_req = 1'b0;
        issue    = 1'b0;
        done     = zero_done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        zero_req = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (room) begin
                    issue = 1'b1;
                    if (remaining_q == ADDR_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_empty) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            first_q     <= 1'b0;
            ret_sop_q   <= 1'b0;
            ret_eop_q   <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= issue;
            zero_done_q <= zero_req;
            if (accept) begin
                addr_q      <= base_addr;
                remaining_q <= length;
                first_q     <= 1'b1;
            end else if (issue) begin
                addr_q      <= (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                first_q     <= 1'b0;
                ret_sop_q   <= first_q;
                ret_eop_q   <= (remaining_q == ADDR_W'(1));
            end
        end
    end

    assign push_entry = '{sop: ret_sop_q, eop: ret_eop_q, data: m_readdata};

    mem_rd_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (st_valid && st_ready),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy         = (state_q != ST_IDLE);
    assign m_address    = addr_q;
    assign m_chipselect = issue;
    assign m_write      = 1'b0;
    assign m_byteenable = 2'b11;
    assign m_clken      = 1'b1;

    assign st_valid = !fifo_empty;
    assign st_data  = head_entry.data;
    assign st_sop   = st_valid && head_entry.sop;
    assign st_eop   = st_valid && head_entry.eop;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench: stimulus queues expected reads/beats, a negedge monitor pops and compares.
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int MEM_WORDS  = 15360;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              busy, done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect, m_write, m_clken;
    logic [1:0]        m_byteenable;
    logic [DATA_W-1:0] m_readdata = '0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid, st_sop, st_eop;
    logic              st_ready = 1'b1;

    onchip_mem_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_sop       (st_sop),
        .st_eop       (st_eop)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency.
    logic [DATA_W-1:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= mem[m_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_beats[$];
    int    exp_addr[$];
    int    issues = 0, beats_total = 0, xfer_beats = 0;
    int    done_count = 0, last_done_cyc = -1, last_eop_cyc = -1, first_beat_cyc = -1;
    logic  prev_stall = 1'b0;
    logic [DATA_W+1:0] prev_out = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(st_valid), 32'd1);
                check("stall_data_held", 32'({st_sop, st_eop, st_data}), 32'(prev_out));
            end
            if (m_chipselect) begin
                issues++;
                check("m_write_low", 32'(m_write), 32'd0);
                if (exp_addr.size() == 0) fail_now("unexpected_read");
                else check("read_addr", 32'(m_address), 32'(exp_addr.pop_front()));
            end
            if (st_valid && st_ready) begin
                if (xfer_beats == 0) first_beat_cyc = cyc;
                xfer_beats++;
                beats_total++;
                if (st_eop) last_eop_cyc = cyc;
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", 32'(st_data), 32'(b.data));
                    check("beat_sop", 32'(st_sop), 32'(b.sop));
                    check("beat_eop", 32'(st_eop), 32'(b.eop));
                end
            end
            if (busy) check("outstanding_le_depth", 32'((issues - beats_total) <= FIFO_DEPTH), 32'd1);
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
            end
            prev_stall = st_valid && !st_ready;
            prev_out   = {st_sop, st_eop, st_data};
        end
    end

    task automatic expect_xfer(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            int    a;
            beat_t b;
            a = (base + i) % MEM_WORDS;
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            b.data = mem[a];
            exp_addr.push_back(a);
            exp_beats.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 32'({busy, done, m_chipselect, st_valid, st_sop, st_eop}), 32'd0);
        check({name, "_addr"}, 32'(m_address), 32'd0);
    endtask

    // ready_mode: 0 = held high, 1 = toggles every 3 cycles, 2 = random.
    task automatic run_xfer(input int base, input int len, input int ready_mode, input bit poke_start);
        int start_cyc, done_before, issues_before;
        bit got;
        expect_xfer(base, len);
        done_before   = done_count;
        issues_before = issues;
        st_ready      = 1'b1;
        @(posedge clk); #1;
        xfer_beats = 0;
        start_cyc  = cyc;
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        length     = ADDR_W'(len);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 0 && len == 0) check("zero_len_busy", 32'(busy), 32'd0);
            if (poke_start && k == 0) begin
                start     = 1'b1;
                base_addr = ADDR_W'(base + 5);
                length    = ADDR_W'(3);
            end
            case (ready_mode)
                0:       st_ready = 1'b1;
                1:       st_ready = ((k / 3) % 2) != 0;
                default: st_ready = 1'($urandom_range(0, 1));
            endcase
            got = (done_count != done_before);
        end
        st_ready = 1'b1;
        start    = 1'b0;
        if (!got) begin
            fail_now("done_timeout");
        end else begin
            check("done_once", 32'(done_count - done_before), 32'd1);
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
            if (len == 0) begin
                check("zero_len_done_cycle", 32'(last_done_cyc), 32'(start_cyc + 1));
                check("zero_len_no_reads", 32'(issues), 32'(issues_before));
            end else if (ready_mode == 0) begin
                check("first_word_latency", 32'(first_beat_cyc), 32'(start_cyc + 3));
                check("done_after_eop", 32'(last_done_cyc), 32'(last_eop_cyc + 1));
            end
        end
        check("beats_all_seen", 32'(exp_beats.size()), 32'd0);
        check("reads_all_seen", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic reset_mid(input int base, input int len);
        int done_before;
        bit hit;
        expect_xfer(base, len);
        done_before = done_count;
        st_ready    = 1'b1;
        @(posedge clk); #1;
        xfer_beats = 0;
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        length     = ADDR_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (xfer_beats >= 5) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!hit) fail_now("reset_mid_timeout");
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        exp_beats.delete();
        exp_addr.delete();
        issues      = 0;
        beats_total = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_mid_no_done", 32'(done_count), 32'(done_before));
        check_reset_outputs("after_reset_idle");
    endtask

    initial begin
        for (int a = 0; a < MEM_WORDS; a++) mem[a] = DATA_W'(a + 'h100);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("idle");
        check("tie_offs", 32'({m_write, m_byteenable, m_clken}), 32'b0111);

        run_xfer('h0010, 8, 0, 1'b0);   // basic transfer
        run_xfer(15358, 4, 0, 1'b0);    // address wrap
        run_xfer(100, 16, 1, 1'b0);     // back-pressure
        run_xfer(50, 0, 0, 1'b0);       // zero length
        run_xfer(7, 1, 0, 1'b1);        // single word, start while busy
        reset_mid(200, 10);
        run_xfer(0, 2, 0, 1'b0);

        for (int a = 0; a < MEM_WORDS; a++) mem[a] = DATA_W'($urandom);
        for (int t = 0; t < 8; t++) begin
            run_xfer(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_mem_stream_reader.md
# onchip_mem_stream_reader

Avalon-MM read master that fetches a contiguous run of 16-bit words from the single-port on-chip pixel memory and emits them as an Avalon-ST stream with start/end-of-packet markers. Sits between the on-chip frame buffer and the downstream video processing pipeline. It drives the memory's slave port directly: fixed read latency of 1 cycle, no waitrequest. Back-pressure is absorbed by a small internal FIFO.

## Interface
- `ADDR_W`, 14: memory word-address width.
- `DATA_W`, 16: memory and stream data width.
- `MEM_WORDS`, 15360: memory depth; the address wraps at this value.
- `FIFO_DEPTH`, 4: output FIFO entries (power of 2, ≥2).

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_W: first word address; latched on an accepted `start`.
- `length` in ADDR_W: number of words; latched on an accepted `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a transfer completes.
- `m_address` out ADDR_W: memory word address.
- `m_chipselect` out 1: read issue strobe.
- `m_write` out 1: tied 0.
- `m_byteenable` out 2: tied 2'b11.
- `m_clken` out 1: tied 1.
- `m_readdata` in DATA_W: memory read data, valid 1 cycle after issue.
- `st_data` out DATA_W: stream data.
- `st_valid` out 1: stream valid.
- `st_ready` in 1: stream ready; a beat transfers when `st_valid & st_ready`.
- `st_sop` out 1: first word of the transfer.
- `st_eop` out 1: last word of the transfer.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - On `start` with `length != 0`: latch `addr = base_addr` and `remaining = length`, then go to RUN.
  - On `start` with `length == 0`: pulse `done` next cycle, issue no reads, stay in IDLE.
- **RUN**
  - Issue a read (`m_chipselect = 1`, `m_address = addr`) in any cycle where `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 1 if a read was issued in the previous cycle, else 0.
  - Each issue does `addr ← (addr == MEM_WORDS-1) ? 0 : addr+1` and `remaining ← remaining-1`.
  - Issuing the final word moves the FSM to DRAIN.
- **Read return**: the cycle after an issue, `m_readdata` is pushed into the FIFO with tag bits:
  - sop = first word of the transfer;
  - eop = last word of the transfer.
  - FIFO entry width is DATA_W+2.
- **DRAIN**: when `inflight == 0`, the FIFO is empty and no beat is pending, go to IDLE and pulse `done` in that same cycle.
- `start` is ignored while `busy`.
- `m_chipselect` is 0 outside RUN. `m_write` is never asserted.
- FIFO never overflows, by construction of the issue rule. A push and a pop in the same cycle leave the count unchanged.
- The FIFO must allow a pop while full.
- `st_data`, `st_sop` and `st_eop` are stable while `st_valid & ~st_ready`.
- Reset values: state IDLE, `busy` 0, `done` 0, `m_chipselect` 0, `m_address` 0, `st_valid` 0, `st_sop` 0, `st_eop` 0, FIFO empty, `inflight` 0.
- Reset asserted mid-transfer aborts the transfer. All in-flight data is discarded and no `done` is produced.

## Timing
- `start` sampled at the end of cycle 0 → first `m_chipselect` in cycle 1.
- That word arrives on `m_readdata` in cycle 2 and is written into the FIFO at the end of cycle 2.
- `st_valid` rises in cycle 3. First-word latency is 3 cycles from `start`.
- Throughput is 1 word/cycle while `st_ready` stays high and `FIFO_DEPTH ≥ 4`.
- With `st_ready` held high, `done` pulses exactly 1 cycle after the eop beat transfers.
- A `start` in the cycle after `done` is accepted; there is no dead cycle.

## Structure
- Shared package `onchip_mem_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - `MEM_WORDS`;
  - the FIFO entry struct {sop, eop, data}.
- One sub-module: `mem_rd_fifo`, a synchronous show-ahead FIFO with count output, same clock and reset, parameterised on width and depth.
- Top level contains the FSM, address/remaining counters, `inflight` flag, and tag generation.

## Test plan
- **Basic transfer**: `base_addr = 0x0010`, `length = 8`, `st_ready` held 1, memory preloaded with addr+0x100 → beats 0x0110…0x0117, sop on the first beat only, eop on the eighth only, `done` 1 cycle after eop, `busy` low on the next cycle.
- **Address wrap**: `base_addr = 15358`, `length = 4` → `m_address` sequence 15358, 15359, 0, 1; data in matching order.
- **Back-pressure**: `length = 16`, `st_ready` toggles 1/0 every 3 cycles → all 16 words in order, no loss or duplication, FIFO count never exceeds 4, `st_data` stable while stalled.
- **Zero length**: `start` with `length = 0` → no `m_chipselect`, `done` pulse 1 cycle later, `busy` stays 0.
- **Single word, and start while busy**: `length = 1` → one beat with sop and eop both high. A second `start` pulsed during RUN is ignored (no extra reads).
- **Reset mid-transfer**: assert `reset` after 5 of 10 beats → all outputs go to reset values immediately. A fresh `start` (`base_addr = 0`, `length = 2`) then completes normally.
